// File: rtl/dm_cache_ctrl_pkg.sv
// Shared cache geometry, bus structs and state encoding for the direct-mapped
// write-back cache controller.
package cache_def;

  localparam int TAGMSB  = 31;
  localparam int TAGLSB  = 14;
  localparam int TAG_W   = TAGMSB - TAGLSB + 1;
  localparam int INDEX_W = 10;
  localparam int NLINES  = 1024;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
    logic        valid;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
    logic           valid;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    ALLOCATE   = 2'd2,
    WRITE_BACK = 2'd3
  } cache_state_type;

  function automatic logic [31:0] line_word(input cache_data_type line, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  function automatic cache_data_type line_put_word(input cache_data_type line,
                                                   input logic [1:0] sel,
                                                   input logic [31:0] w);
    cache_data_type l;
    l = line;
    case (sel)
      2'd0:    l[31:0]   = w;
      2'd1:    l[63:32]  = w;
      2'd2:    l[95:64]  = w;
      default: l[127:96] = w;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and memory-side bus bundle of the cache controller, plus the FSM
// state for observation.
interface dm_cache_ctrl_if;
  import cache_def::*;

  // cpu_req.valid is taken only while cpu_res.ready is high (controller idle);
  // mem_req is held stable until mem_data.ready is seen in a memory-wait state.
  cpu_req_type     cpu_req;
  mem_data_type    mem_data;
  mem_req_type     mem_req;
  cpu_result_type  cpu_res;
  cache_state_type state_dbg;

  modport slave  (input cpu_req, mem_data, output mem_req, cpu_res, state_dbg);
  modport master (output cpu_req, mem_data, input mem_req, cpu_res, state_dbg);
endinterface

// File: rtl/dm_cache_ctrl_store.sv
// Tag and data arrays: asynchronous read, synchronous write; only the valid
// bits carry a reset.
module dm_cache_store
  import cache_def::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  input  logic                tag_we,
  input  cache_tag_type       tag_wdata,
  output cache_tag_type       tag_rdata,
  input  logic                data_we,
  input  cache_data_type      data_wdata,
  output cache_data_type      data_rdata
);

  logic [NLINES-1:0] valid_q, valid_d;
  logic [TAG_W:0]    meta_mem [NLINES];
  cache_data_type    data_mem [NLINES];

  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[index] = tag_wdata.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Dirty bit and tag live beside the data and need no reset: valid gates them.
  always_ff @(posedge clk) begin
    if (tag_we)  meta_mem[index] <= {tag_wdata.dirty, tag_wdata.tag};
    if (data_we) data_mem[index] <= data_wdata;
  end

  assign tag_rdata.valid = valid_q[index];
  assign tag_rdata.dirty = meta_mem[index][TAG_W];
  assign tag_rdata.tag   = meta_mem[index][TAG_W-1:0];
  assign data_rdata      = data_mem[index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: tag compare,
// dirty-line write-back and line refill around a single tag/data store.
module dm_cache_ctrl
  import cache_def::*;
(
  input  logic            clk,
  input  logic            rst_n,
  dm_cache_ctrl_if.slave  bus
);

  cache_state_type state_q, state_d;
  cpu_req_type     req_q, req_d;
  mem_req_type     mem_req_q, mem_req_d;
  logic [31:0]     res_data_q, res_data_d;
  logic            res_valid_q, res_valid_d;

  logic [INDEX_W-1:0] index;
  logic [1:0]         word_sel;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               tag_we, data_we;
  cache_tag_type      tag_rdata, tag_wdata;
  cache_data_type     data_rdata, data_wdata;

  assign index    = req_q.addr[13:4];
  assign word_sel = req_q.addr[3:2];
  assign req_tag  = req_q.addr[TAGMSB:TAGLSB];
  assign hit      = tag_rdata.valid && (tag_rdata.tag == req_tag);

  dm_cache_store u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (index),
    .tag_we     (tag_we),
    .tag_wdata  (tag_wdata),
    .tag_rdata  (tag_rdata),
    .data_we    (data_we),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      mem_req_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mem_req_q   <= mem_req_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.cpu_req.valid) state_d = COMPARE;
      COMPARE: begin
        if (hit)                                      state_d = IDLE;
        else if (tag_rdata.valid && tag_rdata.dirty)  state_d = WRITE_BACK;
        else                                          state_d = ALLOCATE;
      end
      WRITE_BACK: if (bus.mem_data.ready) state_d = ALLOCATE;
      ALLOCATE:   if (bus.mem_data.ready) state_d = COMPARE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    mem_req_d   = mem_req_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    tag_we      = 1'b0;
    tag_wdata   = tag_rdata;
    data_we     = 1'b0;
    data_wdata  = data_rdata;
    case (state_q)
      IDLE: if (bus.cpu_req.valid) req_d = bus.cpu_req;
      COMPARE: begin
        if (hit) begin
          res_data_d  = line_word(data_rdata, word_sel);
          res_valid_d = 1'b1;
          if (req_q.rw) begin
            data_we         = 1'b1;
            data_wdata      = line_put_word(data_rdata, word_sel, req_q.data);
            tag_we          = 1'b1;
            tag_wdata.dirty = 1'b1;
          end
        end else begin
          // Claim the line now; the refill lands before COMPARE is revisited.
          tag_we          = 1'b1;
          tag_wdata.valid = 1'b1;
          tag_wdata.dirty = 1'b0;
          tag_wdata.tag   = req_tag;
          mem_req_d.valid = 1'b1;
          if (tag_rdata.valid && tag_rdata.dirty) begin
            mem_req_d.addr = {tag_rdata.tag, index, 4'b0000};
            mem_req_d.data = data_rdata;
            mem_req_d.rw   = 1'b1;
          end else begin
            mem_req_d.addr = {req_q.addr[31:4], 4'b0000};
            mem_req_d.rw   = 1'b0;
          end
        end
      end
      WRITE_BACK: begin
        if (bus.mem_data.ready) begin
          mem_req_d.addr = {req_q.addr[31:4], 4'b0000};
          mem_req_d.rw   = 1'b0;
        end
      end
      ALLOCATE: begin
        if (bus.mem_data.ready) begin
          data_we         = 1'b1;
          data_wdata      = bus.mem_data.data;
          mem_req_d.valid = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_req       = mem_req_q;
  assign bus.cpu_res.data  = res_data_q;
  assign bus.cpu_res.ready = (state_q == IDLE);
  assign bus.cpu_res.valid = res_valid_q;
  assign bus.state_dbg     = state_q;

  logic unused_ok;
  assign unused_ok = ^{req_q.valid, req_q.addr[1:0], bus.mem_data.valid};

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a vector table of CPU transactions against
// a fixed-latency memory responder, plus hand-written corner sequences.
module tb_dm_cache_ctrl;
  import cache_def::*;

  localparam int MEM_LAT = 3;
  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_cache_ctrl_if bus();

  dm_cache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model / log ----------------
  mem_req_type mem_log[$];
  bit          mem_en = 1'b1;
  int          wc = 0;

  function automatic cache_data_type gen_line(input logic [31:0] a);
    if (a == 32'h0000_1230) return 128'hDDDD_CCCC_BBBB_AAAA_4444_3333_2222_1111;
    return {a | 32'h3, a | 32'h2, a | 32'h1, a};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        bus.mem_data.ready = 1'b0;
        bus.mem_data.valid = 1'b0;
        if (rst_n && bus.mem_req.valid) begin
          if (wc == 0) mem_log.push_back(bus.mem_req);
          if (wc == MEM_LAT) begin
            bus.mem_data.ready = 1'b1;
            bus.mem_data.valid = 1'b1;
            bus.mem_data.data  = gen_line(bus.mem_req.addr);
            wc = 0;
          end else begin
            wc++;
          end
        end else begin
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_ntx;
    logic [31:0] tx0_addr;
    logic        tx0_rw;
    logic [31:0] wb_word;
    logic [31:0] tx1_addr;
  } vec_t;

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_vec(input vec_t v);
    int lat;
    int n0;
    logic [31:0] exp_q[$];
    n0 = mem_log.size();
    exp_q.push_back(v.exp_rdata);
    chk({v.name, " ready_before"}, 128'(bus.cpu_res.ready), 128'(1));
    bus.cpu_req = '{addr: v.addr, data: v.wdata, rw: v.rw, valid: 1'b1};
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req.valid = 1'b0;
    lat = 1;
    while (!bus.cpu_res.valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " timeout"}, 128'(bus.cpu_res.valid), 128'(1));
    if (v.chk_data) chk({v.name, " rdata"}, 128'(bus.cpu_res.data), 128'(exp_q.pop_front()));
    chk({v.name, " latency"}, 128'(lat), 128'(v.exp_lat));
    chk({v.name, " mem_txns"}, 128'(mem_log.size() - n0), 128'(v.exp_ntx));
    if (v.exp_ntx >= 1 && mem_log.size() > n0) begin
      chk({v.name, " tx0_addr"}, 128'(mem_log[n0].addr), 128'(v.tx0_addr));
      chk({v.name, " tx0_rw"}, 128'(mem_log[n0].rw), 128'(v.tx0_rw));
      if (v.tx0_rw)
        chk({v.name, " wb_word"}, 128'(line_word(mem_log[n0].data, v.addr[3:2])), 128'(v.wb_word));
    end
    if (v.exp_ntx >= 2 && mem_log.size() > n0 + 1) begin
      chk({v.name, " tx1_addr"}, 128'(mem_log[n0+1].addr), 128'(v.tx1_addr));
      chk({v.name, " tx1_rw"}, 128'(mem_log[n0+1].rw), 128'(0));
    end
    @(negedge clk);
    chk({v.name, " valid_pulse"}, 128'(bus.cpu_res.valid), 128'(0));
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];

  initial begin
    bit          seen;
    int          n0;
    bus.cpu_req  = '0;
    bus.mem_data = '0;

    //          name          rw    addr          wdata         chk   rdata         lat ntx tx0_addr      rw0   wb_word       tx1_addr
    vecs[0] = '{"cold_rd",   1'b0, 32'h0000_1234, 32'h0,        1'b1, 32'h4444_3333, 7,  1, 32'h0000_1230, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{"hit_rd",    1'b0, 32'h0000_1234, 32'h0,        1'b1, 32'h4444_3333, 2,  0, 32'h0,        1'b0, 32'h0,        32'h0};
    vecs[2] = '{"hit_wr",    1'b1, 32'h0000_1234, 32'hCAFE_F00D, 1'b0, 32'h0,        2,  0, 32'h0,        1'b0, 32'h0,        32'h0};
    vecs[3] = '{"dirty_ev",  1'b0, 32'h0000_5234, 32'h0,        1'b1, 32'h0000_5231, 11, 2, 32'h0000_1230, 1'b1, 32'hCAFE_F00D, 32'h0000_5230};
    vecs[4] = '{"wr_miss",   1'b1, 32'h8000_0008, 32'h1111_2222, 1'b0, 32'h0,        7,  1, 32'h8000_0000, 1'b0, 32'h0,        32'h0};
    vecs[5] = '{"rd_after_wr",1'b0,32'h8000_0008, 32'h0,        1'b1, 32'h1111_2222, 2,  0, 32'h0,        1'b0, 32'h0,        32'h0};
    vecs[6] = '{"dirty_ev2", 1'b0, 32'h8000_4008, 32'h0,        1'b1, 32'h8000_4002, 11, 2, 32'h8000_0000, 1'b1, 32'h1111_2222, 32'h8000_4000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_state", 128'(bus.state_dbg), 128'(IDLE));
    chk("rst_ready", 128'(bus.cpu_res.ready), 128'(1));
    chk("rst_valid", 128'(bus.cpu_res.valid), 128'(0));
    chk("rst_data", 128'(bus.cpu_res.data), 128'(0));
    chk("rst_mem_req", 128'(bus.mem_req), 128'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // mem_data.ready while idle must not disturb anything
    mem_en = 1'b0;
    bus.mem_data.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_state", 128'(bus.state_dbg), 128'(IDLE));
    chk("idle_ready_memv", 128'(bus.mem_req.valid), 128'(0));
    chk("idle_ready_resv", 128'(bus.cpu_res.valid), 128'(0));
    bus.mem_data.ready = 1'b0;
    mem_en = 1'b1;
    @(negedge clk);

    // A second request raised during COMPARE is dropped
    n0 = mem_log.size();
    bus.cpu_req = '{addr: 32'h8000_4008, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(posedge clk);
    @(negedge clk);
    chk("cmp_state", 128'(bus.state_dbg), 128'(COMPARE));
    bus.cpu_req = '{addr: 32'h0000_5234, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    bus.cpu_req.valid = 1'b0;
    chk("cmp_first_valid", 128'(bus.cpu_res.valid), 128'(1));
    chk("cmp_first_data", 128'(bus.cpu_res.data), 128'(32'h8000_4002));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.cpu_res.valid || bus.state_dbg != IDLE) seen = 1'b1;
    end
    chk("cmp_second_dropped", 128'(seen), 128'(0));
    chk("cmp_no_mem", 128'(mem_log.size() - n0), 128'(0));

    // Reset while ALLOCATE waits for memory
    mem_en = 1'b0;
    bus.cpu_req = '{addr: 32'h0000_1234, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req.valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("alloc_state", 128'(bus.state_dbg), 128'(ALLOCATE));
    chk("alloc_memv", 128'(bus.mem_req.valid), 128'(1));
    chk("alloc_addr", 128'(bus.mem_req.addr), 128'(32'h0000_1230));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_memv", 128'(bus.mem_req.valid), 128'(0));
    chk("arst_ready", 128'(bus.cpu_res.ready), 128'(1));
    chk("arst_state", 128'(bus.state_dbg), 128'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b1;
    @(negedge clk);
    run_vec('{"post_rst_5234", 1'b0, 32'h0000_5234, 32'h0, 1'b1, 32'h0000_5231, 7, 1,
              32'h0000_5230, 1'b0, 32'h0, 32'h0});
    run_vec('{"post_rst_1234", 1'b0, 32'h0000_1234, 32'h0, 1'b1, 32'h4444_3333, 7, 1,
              32'h0000_1230, 1'b0, 32'h0, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Controller for a direct-mapped, write-back, write-allocate cache: 1024 lines of 128 bits, 32-bit CPU word interface.
- Sits between the CPU request/result structs and the memory request/response structs defined in cache_def.
- Sequences tag compare, dirty-line write-back and line refill; owns the tag and data stores through one sub-module.

Parameters:
- None at module level. Geometry is fixed by cache_def: TAGMSB=31, TAGLSB=14, 18-bit tag, 10-bit index, 128-bit line.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  cpu_req_type (66)  CPU request: addr, data, rw, valid.
- mem_data  in  mem_data_type (130)  memory response: 128-bit data, ready, valid.
- mem_req  out  mem_req_type (162)  memory request: addr, data, rw, valid.
- cpu_res  out  cpu_result_type (34)  CPU result: data, ready, valid.

Behaviour:
- Address split: tag = addr[31:14], index = addr[13:4], word select = addr[3:2]; addr[1:0] ignored.
- Store: tag array of cache_tag_type (1024 entries) and data array of cache_data_type. Asynchronous read, synchronous write. Only the valid bits are reset.
- Reset values:
  - state = IDLE; all valid bits = 0.
  - mem_req = all zero.
  - cpu_res.data = 0, cpu_res.valid = 0; cpu_res.ready = 1, since ready == (state == IDLE).
- IDLE:
  - cpu_res.ready = 1.
  - On cpu_req.valid: latch the whole cpu_req into req_q and go to COMPARE.
  - cpu_req is ignored in every other state.
- COMPARE: hit = tag[index].valid && tag[index].tag == req_q.addr[31:14].
  - Read hit: cpu_res.data <= selected word, cpu_res.valid <= 1 for exactly one cycle; go to IDLE.
  - Write hit: replace the selected 32-bit word of the line, set dirty = 1, pulse cpu_res.valid, go to IDLE.
  - Miss: write the tag entry to {valid=1, dirty=0, new tag} and assert mem_req.valid.
    - Old entry invalid or clean: mem_req = {addr = {req_q.addr[31:4], 4'b0}, rw = 0}; go to ALLOCATE.
    - Old entry valid and dirty: mem_req = {addr = {old tag, index, 4'b0}, data = old line, rw = 1}; go to WRITE_BACK.
- WRITE_BACK:
  - Hold mem_req stable until mem_data.ready.
  - Then switch mem_req to the refill read (rw = 0, new line addr, valid stays 1) and go to ALLOCATE.
- ALLOCATE:
  - Hold mem_req until mem_data.ready.
  - Then write mem_data.data into the data array at index, drop mem_req.valid, and go to COMPARE. COMPARE now hits and completes the read or write (a write sets dirty).
- Latency, with request seen in IDLE at edge N:
  - Hit: cpu_res.valid is high in cycle N+2.
  - Clean miss: N+2 + (memory wait) + 2.
  - Dirty miss: adds one extra memory transaction.
- mem_data.ready is ignored outside WRITE_BACK and ALLOCATE. mem_data.valid is informational only.
- Back-to-back: a new cpu_req.valid is accepted in the IDLE cycle following cpu_res.valid.
- Reset mid-operation: immediate return to IDLE and mem_req.valid = 0 (asynchronous). All lines are invalidated, so dirty data is discarded. No memory transaction is resumed.
- Index aliasing (same index, different tag) always evicts. There is no replacement choice.

Decomposition:
- Already in cache_def: cache_tag_type, cache_data_type, cpu_req_type, cpu_result_type, mem_req_type, mem_data_type.
- Add to cache_def:
  - state enum cache_state_type {IDLE, COMPARE, ALLOCATE, WRITE_BACK}.
  - localparams INDEX_W = 10, NLINES = 1024.
- Sub-module dm_cache_store holds the tag and data arrays, with ports:
  - index, tag_we, tag_wdata, tag_rdata.
  - data_we, data_wdata, data_rdata.
- The controller FSM and datapath muxing stay in dm_cache_ctrl.

Test Plan:
- Cold read miss: read addr 0x0000_1234 after reset.
  - Required response: mem_req {addr 0x0000_1230, rw 0, valid 1}.
  - Memory returns 0xDDDD_CCCC_BBBB_AAAA_... with ready after 3 cycles.
  - cpu_res.data = word 1 of that line, valid pulses once.
- Read hit: repeat the read of 0x0000_1234.
  - Required response: cpu_res.valid two cycles after request, mem_req.valid stays 0.
- Write hit then dirty eviction:
  - Write 0xCAFE_F00D to 0x0000_1234.
  - Then read 0x0000_5234 (same index, different tag).
  - Required response: mem_req {addr 0x0000_1230, rw 1, data containing 0xCAFE_F00D}, followed by a read of 0x0000_5230.
- Write miss allocate:
  - Write 0x1111_2222 to 0x8000_0008 on a clean line.
  - Then read 0x8000_0008.
  - Required response: the read returns 0x1111_2222 with no memory traffic, and the tag entry is dirty.
- Reset during ALLOCATE:
  - Deassert rst_n while waiting for mem_data.ready.
  - Required response: mem_req.valid = 0 and cpu_res.ready = 1 immediately; a later read of the same address misses again.
- Ignored inputs:
  - Assert mem_data.ready in IDLE → no state change.
  - Assert cpu_req.valid in COMPARE → request not latched; only the first request completes.
